// File: rtl/calib_trim_writer.sv
// Streams the five sensor trim-register writes ({addr, value} frames) to a byte-level
// SPI master after a rising edge on the calibration trigger, with idle gaps between frames.
module calib_trim_writer #(
    parameter logic [7:0]  MBIT_ADDR  = 8'h03,
    parameter logic [7:0]  BIAS_ADDR  = 8'h04,
    parameter logic [7:0]  CLK_ADDR   = 8'h06,
    parameter logic [7:0]  BPA_ADDR   = 8'h07,
    parameter logic [7:0]  PU_ADDR    = 8'h09,
    parameter logic [7:0]  mbit_calib = 8'h00,
    parameter logic [7:0]  bias_calib = 8'h00,
    parameter logic [7:0]  clk_calib  = 8'h00,
    parameter logic [7:0]  bpa_calib  = 8'h00,
    parameter logic [7:0]  pu_calib   = 8'h00,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger_spi_transfer,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] frame_idx
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_ADDR = 3'd1;
    localparam logic [2:0] ST_SEND_DATA = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(4);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] tx_data_nxt;
    logic              tx_valid_nxt, tx_last_nxt, busy_nxt, done_nxt;
    logic [IDX_W-1:0]  frame_idx_nxt;
    logic              trig_prev;
    logic              start;
    logic              handshake;

    assign start     = trigger_spi_transfer & ~trig_prev;
    assign handshake = tx_valid & tx_ready;

    // Frame table: fixed order MBIT, BIAS, CLK, BPA, PU
    function automatic logic [DATA_W-1:0] frame_addr(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(0): frame_addr = MBIT_ADDR;
            IDX_W'(1): frame_addr = BIAS_ADDR;
            IDX_W'(2): frame_addr = CLK_ADDR;
            IDX_W'(3): frame_addr = BPA_ADDR;
            default:   frame_addr = PU_ADDR;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] frame_value(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(0): frame_value = mbit_calib;
            IDX_W'(1): frame_value = bias_calib;
            IDX_W'(2): frame_value = clk_calib;
            IDX_W'(3): frame_value = bpa_calib;
            default:   frame_value = pu_calib;
        endcase
    endfunction

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_nxt     = state;
        gap_cnt_nxt   = gap_cnt;
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = tx_valid;
        tx_last_nxt   = tx_last;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        frame_idx_nxt = frame_idx;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt     = ST_SEND_ADDR;
                    frame_idx_nxt = IDX_W'(0);
                    busy_nxt      = 1'b1;
                    tx_valid_nxt  = 1'b1;
                    tx_last_nxt   = 1'b0;
                    tx_data_nxt   = frame_addr(IDX_W'(0));
                end
            end
            ST_SEND_ADDR: begin
                if (handshake) begin
                    state_nxt   = ST_SEND_DATA;
                    tx_data_nxt = frame_value(frame_idx);
                    tx_last_nxt = 1'b1;
                end
            end
            ST_SEND_DATA: begin
                if (handshake) begin
                    state_nxt    = ST_GAP;
                    tx_valid_nxt = 1'b0;
                    tx_last_nxt  = 1'b0;
                    gap_cnt_nxt  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt != CNT_W'(0)) begin
                    gap_cnt_nxt = gap_cnt - CNT_W'(1);
                end else if (frame_idx != LAST_FRAME) begin
                    state_nxt     = ST_SEND_ADDR;
                    frame_idx_nxt = frame_idx + IDX_W'(1);
                    tx_valid_nxt  = 1'b1;
                    tx_last_nxt   = 1'b0;
                    tx_data_nxt   = frame_addr(frame_idx + IDX_W'(1));
                end else begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt    = ST_IDLE;
                tx_valid_nxt = 1'b0;
                tx_last_nxt  = 1'b0;
                busy_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_idx <= '0;
            trig_prev <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_cnt_nxt;
            tx_data   <= tx_data_nxt;
            tx_valid  <= tx_valid_nxt;
            tx_last   <= tx_last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            frame_idx <= frame_idx_nxt;
            trig_prev <= trigger_spi_transfer;
        end
    end

endmodule

// File: tb/tb_calib_trim_writer.sv
// Randomized bench for calib_trim_writer: two instances (gap 16 and gap 1) checked
// against an expected byte-stream model built from the trim table.
module tb_calib_trim_writer;

    localparam int unsigned GAP_A   = 16;
    localparam int unsigned GAP_B   = 1;
    localparam int unsigned NFRAMES = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig, ready;
    logic [7:0] a_data;
    logic       a_valid, a_last, a_busy, a_done;
    logic [2:0] a_idx;
    logic       b_trig, b_ready;
    logic [7:0] b_data;
    logic       b_valid, b_last, b_busy, b_done;
    logic [2:0] b_idx;

    always #5 clk = ~clk;

    calib_trim_writer #(
        .mbit_calib(8'h0C), .bias_calib(8'h05), .clk_calib(8'h15),
        .bpa_calib(8'h0C), .pu_calib(8'h88), .GAP_CYCLES(GAP_A)
    ) dut_a (
        .clk(clk), .rst(rst), .trigger_spi_transfer(trig),
        .tx_data(a_data), .tx_valid(a_valid), .tx_last(a_last), .tx_ready(ready),
        .busy(a_busy), .done(a_done), .frame_idx(a_idx)
    );

    calib_trim_writer #(
        .mbit_calib(8'h0C), .bias_calib(8'h05), .clk_calib(8'h15),
        .bpa_calib(8'h0C), .pu_calib(8'h88), .GAP_CYCLES(GAP_B)
    ) dut_b (
        .clk(clk), .rst(rst), .trigger_spi_transfer(b_trig),
        .tx_data(b_data), .tx_valid(b_valid), .tx_last(b_last), .tx_ready(b_ready),
        .busy(b_busy), .done(b_done), .frame_idx(b_idx)
    );

    logic [7:0] ref_addr [NFRAMES] = '{8'h03, 8'h04, 8'h06, 8'h07, 8'h09};
    logic [7:0] ref_val  [NFRAMES] = '{8'h0C, 8'h05, 8'h15, 8'h0C, 8'h88};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Observed-port mux so one monitor serves either instance
    logic       sel;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_busy, m_done, m_ready;
    logic [2:0] m_idx;
    int         gap_exp;

    always_comb begin
        m_data  = sel ? b_data  : a_data;
        m_valid = sel ? b_valid : a_valid;
        m_last  = sel ? b_last  : a_last;
        m_busy  = sel ? b_busy  : a_busy;
        m_done  = sel ? b_done  : a_done;
        m_ready = sel ? b_ready : ready;
        m_idx   = sel ? b_idx   : a_idx;
        gap_exp = sel ? int'(GAP_B) : int'(GAP_A);
    end

    int         cyc = 0;
    int         gap_run = 0;
    int         done_cnt = 0;
    int         seq_start = 0;
    bit         busy_q = 1'b0;
    bit         stall_q = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;
    bit         timing_en;
    logic [8:0] obs_q [$];

    // Monitor on the falling edge: handshakes, stall stability, gaps, done timing
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            stall_q = 1'b0;
            gap_run = 0;
            busy_q  = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(stall_data));
                check("stall_last", 32'(m_last), 32'(stall_last));
            end
            if (m_busy && !busy_q) seq_start = cyc;
            busy_q = m_busy;
            if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
            stall_q    = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (m_busy && !m_valid) begin
                gap_run++;
            end else if (m_valid && gap_run != 0) begin
                check("frame_gap", 32'(gap_run), 32'(gap_exp));
                gap_run = 0;
            end
            if (m_done) begin
                done_cnt++;
                check("done_gap", 32'(gap_run), 32'(gap_exp));
                gap_run = 0;
                check("done_busy", 32'(m_busy), 32'd0);
                check("done_idx", 32'(m_idx), 32'd4);
                if (timing_en)
                    check("seq_len", 32'(cyc - seq_start), 32'(int'(NFRAMES) * (2 + gap_exp)));
            end
        end
    end

    bit bp = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp) ready = 1'($urandom() & 1);
    endtask

    task automatic pulse_a();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        if (done_cnt < target) check({tag, "_timeout"}, 32'(done_cnt), 32'(target));
    endtask

    // Expected stream: reps back-to-back copies of {addr, value} for each frame
    task automatic cmp_stream(input int base, input int reps, input string tag);
        int n   = obs_q.size() - base;
        int exp_n = 2 * int'(NFRAMES) * reps;
        check({tag, "_nbytes"}, 32'(n), 32'(exp_n));
        for (int i = 0; i < n && i < exp_n; i++) begin
            int         f = (i / 2) % int'(NFRAMES);
            logic [8:0] e;
            e = (i % 2 == 0) ? {1'b0, ref_addr[f]} : {1'b1, ref_val[f]};
            check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[base + i]), 32'(e));
        end
    endtask

    initial begin
        int base;
        int d0;
        int k;
        sel = 1'b0; rst = 1'b1; trig = 1'b0; ready = 1'b1;
        b_trig = 1'b0; b_ready = 1'b1; timing_en = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_last", 32'(a_last), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_idx", 32'(a_idx), 32'd0);
        rst = 1'b0;
        repeat ($urandom_range(2, 6)) tick();

        // Plain sequence, ready held high
        base = obs_q.size(); d0 = done_cnt;
        pulse_a();
        wait_done(d0 + 1, 400, "seq");
        repeat (20) tick();
        cmp_stream(base, 1, "seq");
        check("seq_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("seq_idx_hold", 32'(a_idx), 32'd4);

        // Random backpressure
        timing_en = 1'b0; bp = 1'b1;
        base = obs_q.size(); d0 = done_cnt;
        pulse_a();
        wait_done(d0 + 1, 3000, "bp");
        bp = 1'b0; ready = 1'b1;
        repeat (20) tick();
        cmp_stream(base, 1, "bp");
        check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
        timing_en = 1'b1;

        // Held trigger: one sequence per rising edge
        base = obs_q.size(); d0 = done_cnt;
        trig = 1'b1;
        repeat (500) tick();
        check("held_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("held_nbytes", 32'(obs_q.size() - base), 32'd10);
        trig = 1'b0;
        repeat ($urandom_range(2, 20)) tick();
        check("held_low_done", 32'(done_cnt - d0), 32'd1);
        trig = 1'b1;
        wait_done(d0 + 2, 400, "held2");
        repeat (10) tick();
        trig = 1'b0;
        repeat (10) tick();
        cmp_stream(base, 2, "held");
        check("held2_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Second edge while busy is ignored
        base = obs_q.size(); d0 = done_cnt;
        pulse_a();
        k = 0;
        while (a_idx != 3'd2 && k < 200) begin tick(); k++; end
        check("busy_reach_f2", 32'(a_idx), 32'd2);
        check("busy_at_f2", 32'(a_busy), 32'd1);
        repeat ($urandom_range(0, 5)) tick();
        pulse_a();
        wait_done(d0 + 1, 400, "busy");
        repeat (150) tick();
        cmp_stream(base, 1, "busy");
        check("busy_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset while frame 1 data byte is stalled
        pulse_a();
        k = 0;
        while (!(a_idx == 3'd1 && a_valid && a_last) && k < 200) begin tick(); k++; end
        ready = 1'b0;
        check("mid_reach", 32'({a_idx == 3'd1, a_valid, a_last}), 32'd7);
        repeat ($urandom_range(1, 4)) tick();
        check("mid_stall_valid", 32'(a_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(a_valid), 32'd0);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        check("mid_rst_idx", 32'(a_idx), 32'd0);
        rst = 1'b0; ready = 1'b1;
        repeat (3) tick();
        check("mid_no_restart", 32'(a_valid), 32'd0);
        base = obs_q.size(); d0 = done_cnt;
        pulse_a();
        wait_done(d0 + 1, 400, "mid");
        repeat (5) tick();
        cmp_stream(base, 1, "mid");

        // Single-cycle gap instance
        sel = 1'b1;
        repeat (2) tick();
        base = obs_q.size(); d0 = done_cnt;
        b_trig = 1'b1;
        tick();
        b_trig = 1'b0;
        wait_done(d0 + 1, 200, "g1");
        repeat (5) tick();
        cmp_stream(base, 1, "g1");
        check("g1_done_cnt", 32'(done_cnt - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no completion, expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/calib_trim_writer.md
Name: calib_trim_writer

Overview:
Downstream stage of the sensor calibration trigger. It consumes the level trigger `trigger_spi_transfer` and streams the five trim-register writes (MBIT, BIAS, CLK, BPA, PU) to the byte-level SPI master. Each write is a two-byte frame: register address, then trim value. The SPI master owns chip-select and the serial timing; this block only sequences bytes, frame boundaries and inter-frame gaps.

Parameters:
MBIT_ADDR, 8'h03, sensor register address of MBIT trim
BIAS_ADDR, 8'h04, register address of BIAS trim
CLK_ADDR, 8'h06, register address of CLK trim
BPA_ADDR, 8'h07, register address of BPA trim
PU_ADDR, 8'h09, register address of PU trim
mbit_calib, 8'h00, MBIT trim value
bias_calib, 8'h00, BIAS trim value
clk_calib, 8'h00, CLK trim value
bpa_calib, 8'h00, BPA trim value
pu_calib, 8'h00, PU trim value
GAP_CYCLES, 16, idle clocks between frames (CS-high time); legal range 1..65535

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
trigger_spi_transfer  input  1  level request from calibration trigger
tx_data  output  8  byte to SPI master
tx_valid  output  1  tx_data valid
tx_last  output  1  current byte ends a frame (master deasserts CS after it)
tx_ready  input  1  SPI master accepts byte when tx_valid & tx_ready
busy  output  1  sequence in progress
done  output  1  one-cycle pulse after the last frame's gap completes
frame_idx  output  3  index of current/last frame, 0..4

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; tx_valid=0, tx_last=0, tx_data=0, busy=0, done=0, frame_idx=0; the trigger edge register is cleared to 0. Takes priority over every other event, including mid-transfer; any byte not yet accepted is dropped.
- Start: 1-cycle registered rising-edge detect on trigger_spi_transfer (prev=0, cur=1), evaluated only in IDLE. A held-high level does not restart the sequence. Edges during busy are ignored and are not queued.
- Frame table, fixed order: 0 MBIT, 1 BIAS, 2 CLK, 3 BPA, 4 PU. Each frame is {ADDR, value}.
- States:
  - IDLE: on start edge -> SEND_ADDR, frame_idx=0, busy=1. tx_valid rises in the cycle after the edge is registered.
  - SEND_ADDR: tx_valid=1, tx_data=ADDR[frame_idx], tx_last=0. On handshake -> SEND_DATA.
  - SEND_DATA: tx_valid=1, tx_data=value[frame_idx], tx_last=1. On handshake -> GAP, with gap counter loaded to GAP_CYCLES-1.
  - GAP: tx_valid=0. The counter decrements to 0, so the state lasts exactly GAP_CYCLES cycles. At 0: if frame_idx<4, increment frame_idx -> SEND_ADDR; else -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that same cycle -> IDLE. frame_idx holds 4 until the next start.
- Handshake rules: tx_data and tx_last stay stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a handshake (except on reset). Back-to-back acceptance gives 1 byte/cycle within a frame.
- busy is 1 from the first cycle of SEND_ADDR through the last GAP cycle.
- Minimum sequence length with tx_ready held at 1: 5 × (2 + GAP_CYCLES) cycles, plus the DONE cycle.
- tx_ready is ignored while tx_valid=0.

Test Plan:
- Default-gap sequence: params mbit=8'h0C, bias=8'h05, clk=8'h15, bpa=8'h0C, pu=8'h88, GAP_CYCLES=16, tx_ready=1. Pulse trigger -> bytes 03,0C,04,05,06,15,07,0C,09,88. tx_last=1 on every second byte. Exactly 16 idle cycles between frames. done pulses once 90 cycles after the first tx_valid.
- Backpressure: tx_ready toggles 0/1 randomly -> same byte stream. tx_data/tx_last stable while stalled. No byte duplicated or lost.
- Held trigger: trigger high for 500 cycles, then low, then high again -> exactly two complete sequences. Second starts only on the re-rise after done.
- Trigger during busy: a second rising edge at frame 2 -> ignored. Exactly 10 bytes total, one done pulse.
- Reset mid-operation: assert rst during SEND_DATA of frame 1 with tx_ready=0 -> next cycle tx_valid=0, busy=0, frame_idx=0. A new trigger edge restarts from byte 03.
- GAP_CYCLES=1: tx_ready=1 -> exactly one idle cycle between frames. Total 15 cycles from first tx_valid to done.
